// File: rtl/max30102_pkg.sv
// Shared constants and types for the MAX30102 sequencer: register map,
// init write values, FSM state encoding and the write-entry payload.
package max30102_pkg;

    localparam int unsigned IDX_W    = 3;
    localparam int unsigned INIT_LEN = 6;
    localparam int unsigned READ_LEN = 6;
    localparam int unsigned STATE_W  = 3;

    localparam logic [7:0] REG_FIFO_DATA   = 8'h07;
    localparam logic [7:0] REG_FIFO_CONFIG = 8'h08;
    localparam logic [7:0] REG_MODE_CONFIG = 8'h09;
    localparam logic [7:0] REG_SPO2_CONFIG = 8'h0A;
    localparam logic [7:0] REG_LED1_PA     = 8'h0C;
    localparam logic [7:0] REG_LED2_PA     = 8'h0D;

    localparam logic [7:0] MODE_SOFT_RESET = 8'h40;
    localparam logic [7:0] MODE_SPO2       = 8'h03;
    localparam logic [7:0] SPO2_CFG_VAL    = 8'h27;
    localparam logic [7:0] LED1_PA_VAL     = 8'h24;
    localparam logic [7:0] LED2_PA_VAL     = 8'h24;
    localparam logic [7:0] FIFO_CFG_VAL    = 8'h4F;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_ISSUE       = 3'd1,
        ST_WAIT_ACCEPT = 3'd2,
        ST_WAIT_DONE   = 3'd3,
        ST_RST_WAIT    = 3'd4,
        ST_WAIT_PERIOD = 3'd5,
        ST_PUBLISH     = 3'd6,
        ST_ERROR       = 3'd7
    } state_e;

    typedef enum logic {
        PH_INIT = 1'b0,
        PH_READ = 1'b1
    } phase_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } i2c_wr_t;

endpackage

// File: rtl/max30102_init_rom.sv
// Init write table: index -> {register, data}, applied in index order.
module max30102_init_rom
    import max30102_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output i2c_wr_t          entry_o
);

    always_comb begin
        entry_o = '0;
        case (idx_i)
            3'd0:    entry_o = '{reg_addr: REG_MODE_CONFIG, data: MODE_SOFT_RESET};
            3'd1:    entry_o = '{reg_addr: REG_MODE_CONFIG, data: MODE_SPO2};
            3'd2:    entry_o = '{reg_addr: REG_SPO2_CONFIG, data: SPO2_CFG_VAL};
            3'd3:    entry_o = '{reg_addr: REG_LED1_PA,     data: LED1_PA_VAL};
            3'd4:    entry_o = '{reg_addr: REG_LED2_PA,     data: LED2_PA_VAL};
            3'd5:    entry_o = '{reg_addr: REG_FIFO_CONFIG, data: FIFO_CFG_VAL};
            default: entry_o = '0;
        endcase
    end

endmodule

// File: rtl/max30102_seq_ctrl.sv
// MAX30102 sequencer: runs the init write table through the single-register
// I2C master, then reads the 6 FIFO bytes periodically and publishes RED/IR.
module max30102_seq_ctrl
    import max30102_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR    = 7'h57,
    parameter int unsigned SAMPLE_PERIOD = 10000,
    parameter int unsigned RESET_DELAY   = 1000,
    parameter int unsigned TIMEOUT       = 4095
) (
    input  logic        clk_1MHz,
    input  logic        rst_n,
    input  logic        enable,
    output logic        i2c_start,
    output logic        i2c_rw,
    output logic [6:0]  i2c_slave_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_data_wr,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_ready,
    output logic [17:0] red_data,
    output logic [17:0] ir_data,
    output logic        sample_valid,
    output logic        init_done,
    output logic        busy,
    output logic        error
);

    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int unsigned DLY_W = $clog2(RESET_DELAY + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [PER_W-1:0]     per_q, per_d;
    logic [5:0][7:0]      bytes_q, bytes_d;

    logic                 start_q, start_d;
    logic                 rw_q, rw_d;
    logic [7:0]           reg_q, reg_d;
    logic [7:0]           wr_q, wr_d;
    logic [17:0]          red_q, red_d;
    logic [17:0]          ir_q, ir_d;
    logic                 valid_q, valid_d;
    logic                 init_done_q, init_done_d;
    logic                 busy_q, busy_d;
    logic                 error_q, error_d;

    i2c_wr_t              rom_entry;

    max30102_init_rom u_init_rom (
        .idx_i   (idx_q),
        .entry_o (rom_entry)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        dly_d       = dly_q;
        per_d       = (per_q == PER_W'(SAMPLE_PERIOD)) ? per_q : per_q + 1'b1;
        bytes_d     = bytes_q;
        start_d     = 1'b0;
        rw_d        = rw_q;
        reg_d       = reg_q;
        wr_d        = wr_q;
        red_d       = red_q;
        ir_d        = ir_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        error_d     = error_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ISSUE;
                    phase_d = PH_INIT;
                    idx_d   = '0;
                end
            end

            ST_ISSUE: begin
                // Transaction fields latch here and stay put until completion.
                rw_d  = (phase_q == PH_READ);
                reg_d = (phase_q == PH_READ) ? REG_FIFO_DATA : rom_entry.reg_addr;
                wr_d  = (phase_q == PH_READ) ? 8'h00 : rom_entry.data;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (i2c_ready) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_ACCEPT;
                    tmo_d   = '0;
                end
            end

            ST_WAIT_ACCEPT: begin
                if (!i2c_ready) begin
                    state_d = ST_WAIT_DONE;
                    tmo_d   = '0;
                end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_WAIT_DONE: begin
                if (i2c_ready) begin
                    if (phase_q == PH_READ) begin
                        bytes_d[idx_q] = i2c_data_rd;
                    end
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (phase_q == PH_INIT) begin
                        if (idx_q == '0) begin
                            state_d = ST_RST_WAIT;
                            dly_d   = '0;
                        end else if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                            // Preloaded period makes the first burst immediate.
                            init_done_d = 1'b1;
                            state_d     = ST_WAIT_PERIOD;
                            per_d       = PER_W'(SAMPLE_PERIOD);
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = ST_ISSUE;
                        end
                    end else if (idx_q == IDX_W'(READ_LEN - 1)) begin
                        state_d = ST_PUBLISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_RST_WAIT: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (dly_q == DLY_W'(RESET_DELAY - 1)) begin
                    state_d = ST_ISSUE;
                    idx_d   = IDX_W'(1);
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end

            ST_WAIT_PERIOD: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (per_q >= PER_W'(SAMPLE_PERIOD - 1)) begin
                    state_d = ST_ISSUE;
                    phase_d = PH_READ;
                    idx_d   = '0;
                    per_d   = '0;
                end
            end

            ST_PUBLISH: begin
                red_d   = {bytes_q[0][1:0], bytes_q[1], bytes_q[2]};
                ir_d    = {bytes_q[3][1:0], bytes_q[4], bytes_q[5]};
                valid_d = 1'b1;
                state_d = ST_WAIT_PERIOD;
            end

            ST_ERROR: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERROR) begin
            error_d     = 1'b1;
            init_done_d = 1'b0;
        end
        if (state_d == ST_IDLE) begin
            error_d     = 1'b0;
            init_done_d = 1'b0;
        end
        busy_d = !(state_d inside {ST_IDLE, ST_ERROR});
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_INIT;
            idx_q       <= '0;
            tmo_q       <= '0;
            dly_q       <= '0;
            per_q       <= '0;
            bytes_q     <= '0;
            start_q     <= 1'b0;
            rw_q        <= 1'b0;
            reg_q       <= '0;
            wr_q        <= '0;
            red_q       <= '0;
            ir_q        <= '0;
            valid_q     <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            dly_q       <= dly_d;
            per_q       <= per_d;
            bytes_q     <= bytes_d;
            start_q     <= start_d;
            rw_q        <= rw_d;
            reg_q       <= reg_d;
            wr_q        <= wr_d;
            red_q       <= red_d;
            ir_q        <= ir_d;
            valid_q     <= valid_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
        end
    end

    assign i2c_start      = start_q;
    assign i2c_rw         = rw_q;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_reg_addr   = reg_q;
    assign i2c_data_wr    = wr_q;
    assign red_data       = red_q;
    assign ir_data        = ir_q;
    assign sample_valid   = valid_q;
    assign init_done      = init_done_q;
    assign busy           = busy_q;
    assign error          = error_q;

endmodule

// File: tb/tb_max30102_seq_ctrl.sv
// Bench for max30102_seq_ctrl: behavioural I2C master returning random FIFO
// bytes, transaction log and sample scoreboard derived from the byte stream.
module tb_max30102_seq_ctrl;

    localparam int unsigned SP = 200;
    localparam int unsigned RD = 1000;
    localparam int unsigned TO = 300;

    logic        clk_1MHz = 1'b0;
    logic        rst_n    = 1'b1;
    logic        enable   = 1'b0;
    logic        i2c_ready = 1'b1;
    logic [7:0]  i2c_data_rd = 8'h00;
    logic        i2c_start, i2c_rw, sample_valid, init_done, busy, error;
    logic [6:0]  i2c_slave_addr;
    logic [7:0]  i2c_reg_addr, i2c_data_wr;
    logic [17:0] red_data, ir_data;

    max30102_seq_ctrl #(
        .SLAVE_ADDR    (7'h57),
        .SAMPLE_PERIOD (SP),
        .RESET_DELAY   (RD),
        .TIMEOUT       (TO)
    ) dut (
        .clk_1MHz       (clk_1MHz),
        .rst_n          (rst_n),
        .enable         (enable),
        .i2c_start      (i2c_start),
        .i2c_rw         (i2c_rw),
        .i2c_slave_addr (i2c_slave_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_data_wr    (i2c_data_wr),
        .i2c_data_rd    (i2c_data_rd),
        .i2c_ready      (i2c_ready),
        .red_data       (red_data),
        .ir_data        (ir_data),
        .sample_valid   (sample_valid),
        .init_done      (init_done),
        .busy           (busy),
        .error          (error)
    );

    initial forever #5 clk_1MHz = ~clk_1MHz;

    typedef struct {
        int unsigned t;
        logic        rw;
        logic [7:0]  ra;
        logic [7:0]  wd;
    } txn_t;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    txn_t        log_q[$];
    int unsigned valid_t[$];
    logic [17:0] exp_red[$];
    logic [17:0] exp_ir[$];
    logic [7:0]  acc[$];
    logic [7:0]  fixed_q[$];
    bit          stuck = 1'b0;
    int          lat = 20;
    logic        prev_start = 1'b0;
    bit          have_first = 1'b0;
    logic [17:0] first_red = '0;
    logic [17:0] first_ir = '0;
    logic [7:0]  tbl_reg[6] = '{8'h09, 8'h09, 8'h0A, 8'h0C, 8'h0D, 8'h08};
    logic [7:0]  tbl_dat[6] = '{8'h40, 8'h03, 8'h27, 8'h24, 8'h24, 8'h4F};

    always @(posedge clk_1MHz) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Master: ready drops one cycle after start, returns after lat cycles.
    initial begin
        logic       is_rd;
        int         cur_lat;
        logic [7:0] b;
        logic [17:0] r, ir;
        forever begin
            @(negedge clk_1MHz);
            if (rst_n && i2c_start === 1'b1 && !stuck) begin
                is_rd   = i2c_rw;
                cur_lat = lat;
                @(negedge clk_1MHz);
                i2c_ready = 1'b0;
                repeat (cur_lat - 1) @(negedge clk_1MHz);
                if (is_rd) begin
                    b = (fixed_q.size() != 0) ? fixed_q.pop_front() : 8'($urandom);
                    i2c_data_rd = b;
                    acc.push_back(b);
                    if (acc.size() == 6) begin
                        r  = 18'((acc[0] % 4) * 65536 + acc[1] * 256 + acc[2]);
                        ir = 18'((acc[3] % 4) * 65536 + acc[4] * 256 + acc[5]);
                        exp_red.push_back(r);
                        exp_ir.push_back(ir);
                        acc.delete();
                    end
                end
                i2c_ready = 1'b1;
            end
        end
    end

    // Monitor: logs starts, checks start legality and scores samples.
    always @(negedge clk_1MHz) begin
        if (rst_n) begin
            if (i2c_start === 1'b1) begin
                check_eq("start_while_busy", 32'(i2c_ready), 1);
                check_eq("start_twice", 32'(prev_start), 0);
                check_eq("slave_addr", 32'(i2c_slave_addr), 32'h57);
                log_q.push_back('{t: cyc, rw: i2c_rw, ra: i2c_reg_addr, wd: i2c_data_wr});
            end
            if (sample_valid === 1'b1) begin
                valid_t.push_back(cyc);
                if (!have_first) begin
                    first_red  = red_data;
                    first_ir   = ir_data;
                    have_first = 1'b1;
                end
                if (exp_red.size() == 0) begin
                    check_eq("valid_unexpected", 32'(sample_valid), 0);
                end else begin
                    check_eq("red_data", 32'(red_data), 32'(exp_red.pop_front()));
                    check_eq("ir_data", 32'(ir_data), 32'(exp_ir.pop_front()));
                end
            end
        end
        prev_start = i2c_start;
    end

    task automatic wait_log(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && log_q.size() < n; k++) @(negedge clk_1MHz);
        check_eq(tag, 32'(log_q.size() >= n), 1);
    endtask

    task automatic wait_valid(input int n, input int budget, input string tag);
        for (int k = 0; k < budget && valid_t.size() < n; k++) @(negedge clk_1MHz);
        check_eq(tag, 32'(valid_t.size() >= n), 1);
    endtask

    task automatic wait_init_done(input string tag);
        for (int k = 0; k < 200 && init_done !== 1'b1; k++) @(negedge clk_1MHz);
        check_eq(tag, 32'(init_done), 1);
    endtask

    task automatic check_init(input int base, input string tag);
        for (int k = 0; k < 6; k++) begin
            if (base + k < log_q.size()) begin
                check_eq($sformatf("%s_reg%0d", tag, k), 32'(log_q[base + k].ra), 32'(tbl_reg[k]));
                check_eq($sformatf("%s_dat%0d", tag, k), 32'(log_q[base + k].wd), 32'(tbl_dat[k]));
                check_eq($sformatf("%s_rw%0d", tag, k), 32'(log_q[base + k].rw), 0);
            end else begin
                check_eq($sformatf("%s_missing%0d", tag, k), 32'(log_q.size()), 32'(base + k + 1));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_start"}, 32'(i2c_start), 0);
        check_eq({tag, "_rw"}, 32'(i2c_rw), 0);
        check_eq({tag, "_reg"}, 32'(i2c_reg_addr), 0);
        check_eq({tag, "_wr"}, 32'(i2c_data_wr), 0);
        check_eq({tag, "_red"}, 32'(red_data), 0);
        check_eq({tag, "_ir"}, 32'(ir_data), 0);
        check_eq({tag, "_valid"}, 32'(sample_valid), 0);
        check_eq({tag, "_init_done"}, 32'(init_done), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_error"}, 32'(error), 0);
        check_eq({tag, "_slave"}, 32'(i2c_slave_addr), 32'h57);
    endtask

    function automatic int unsigned first_start_after(input int unsigned t);
        foreach (log_q[i]) if (log_q[i].t > t) return log_q[i].t;
        return 0;
    endfunction

    initial begin
        int          n, nv, base;
        int unsigned gap, t0, d;
        fixed_q = '{8'hFD, 8'h23, 8'h45, 8'h01, 8'h67, 8'h89};

        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst0");
        repeat (3) @(negedge clk_1MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_1MHz);
        check_eq("idle_busy", 32'(busy), 0);

        // Init table, reset gap, first burst and steady period.
        enable = 1'b1;
        @(negedge clk_1MHz);
        check_eq("busy_after_enable", 32'(busy), 1);
        wait_log(6, 5000, "init_txns");
        check_eq("init_done_early", 32'(init_done), 0);
        check_init(0, "init");
        gap = log_q[1].t - log_q[0].t;
        check_eq("rst_gap", 32'(gap >= RD + 20 && gap <= RD + 25), 1);
        wait_init_done("init_done");
        wait_valid(4, 2000, "samples_a");
        check_eq("first_red", 32'(first_red), 32'h12345);
        check_eq("first_ir", 32'(first_ir), 32'h16789);
        check_eq("rd_reg", 32'(log_q[6].ra), 32'h07);
        check_eq("rd_rw", 32'(log_q[6].rw), 1);
        for (int b = 1; b < 4; b++)
            check_eq($sformatf("period%0d", b), log_q[6 + 6 * b].t - log_q[6 * b].t, SP);

        // Overrun: bursts longer than the period restart right after publish.
        lat = 50;
        nv = valid_t.size();
        wait_valid(nv + 3, 3000, "samples_b");
        for (int i = 0; i < 2; i++) begin
            d = first_start_after(valid_t[nv + i]) - valid_t[nv + i];
            check_eq($sformatf("overrun_restart%0d", i), 32'(d >= 1 && d <= 3), 1);
        end

        // Disable while the fourth read of a burst is in flight.
        lat = 20;
        wait_valid(valid_t.size() + 1, 1000, "samples_c");
        for (int k = 0; k < 2000 && ((log_q.size() - 6) % 6) != 4; k++) @(negedge clk_1MHz);
        check_eq("abort_point", 32'((log_q.size() - 6) % 6), 4);
        repeat (5) @(negedge clk_1MHz);
        enable = 1'b0;
        n  = log_q.size();
        nv = valid_t.size();
        repeat (100) @(negedge clk_1MHz);
        check_eq("abort_nostart", 32'(log_q.size()), 32'(n));
        check_eq("abort_novalid", 32'(valid_t.size()), 32'(nv));
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_init_done", 32'(init_done), 0);
        check_eq("abort_master_idle", 32'(i2c_ready), 1);
        acc.delete();
        enable = 1'b1;
        wait_log(n + 6, 5000, "reinit_txns");
        check_init(n, "reinit");
        wait_init_done("reinit_done");
        wait_valid(nv + 1, 1000, "samples_c2");

        // Master never accepts: timeout to ERROR, held until disable.
        stuck = 1'b1;
        n = log_q.size();
        wait_log(n + 1, 500, "stuck_start");
        t0 = log_q[n].t;
        for (int k = 0; k < int'(TO) + 50 && error !== 1'b1; k++) @(negedge clk_1MHz);
        d = cyc - t0;
        check_eq("error_set", 32'(error), 1);
        check_eq("error_latency", 32'(d + 1 >= TO && d <= TO + 2), 1);
        check_eq("error_init_done", 32'(init_done), 0);
        check_eq("error_busy", 32'(busy), 0);
        repeat (200) @(negedge clk_1MHz);
        check_eq("error_nostart", 32'(log_q.size()), 32'(n + 1));
        check_eq("error_held", 32'(error), 1);
        enable = 1'b0;
        repeat (2) @(negedge clk_1MHz);
        check_eq("error_clear", 32'(error), 0);
        check_eq("error_idle_busy", 32'(busy), 0);
        stuck = 1'b0;
        acc.delete();

        // Asynchronous reset in the middle of a burst.
        enable = 1'b1;
        base = log_q.size();
        wait_log(base + 6, 5000, "init3_txns");
        nv = valid_t.size();
        wait_valid(nv + 1, 1000, "samples_e");
        n = log_q.size();
        wait_log(n + 1, 500, "burst_e");
        repeat (10) @(negedge clk_1MHz);
        rst_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        enable = 1'b0;
        repeat (100) @(negedge clk_1MHz);
        acc.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk_1MHz);
        enable = 1'b1;
        n = log_q.size();
        wait_log(n + 6, 5000, "post_rst_txns");
        check_init(n, "post_rst");
        wait_init_done("post_rst_done");
        wait_valid(valid_t.size() + 1, 1000, "samples_f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/max30102_seq_ctrl.md
Name: max30102_seq_ctrl

Overview:
- Sequencer that drives the single-register I2C master (start/rw/slave_addr/reg_addr/data_in/data_out/ready) for the MAX30102 pulse-oximeter.
- After enable it runs a fixed init write table, then periodically reads the 6 FIFO bytes and publishes 18-bit RED/IR samples.
- Sits between the I2C master and the sample-processing datapath; the only issuer of I2C transactions on that bus.

Parameters:
- SLAVE_ADDR, 7'h57, 7-bit device address driven on every transaction.
- SAMPLE_PERIOD, 10000, clk_1MHz cycles between read-burst starts (100 Hz).
- RESET_DELAY, 1000, cycles waited after the soft-reset write.
- TIMEOUT, 4095, max cycles in any wait-for-master state before error.

Ports:
- clk_1MHz  in  1  system clock, 1 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = run init then sampling, 0 = go idle.
- i2c_start  out  1  one-cycle start pulse to master.
- i2c_rw  out  1  0 write, 1 read.
- i2c_slave_addr  out  7  always SLAVE_ADDR.
- i2c_reg_addr  out  8  register address of current transaction.
- i2c_data_wr  out  8  write data of current transaction.
- i2c_data_rd  in  8  read data from master, valid when i2c_ready rises.
- i2c_ready  in  1  master idle/done.
- red_data  out  18  last RED sample.
- ir_data  out  18  last IR sample.
- sample_valid  out  1  one-cycle pulse when red_data/ir_data update.
- init_done  out  1  high after init table completes, until disable or error.
- busy  out  1  high in any state except IDLE and ERROR.
- error  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_n low, async): state IDLE; all outputs 0, except i2c_slave_addr = SLAVE_ADDR. Counters and byte buffer cleared.
- Init table, in order (reg,data): (09,40) soft reset; (09,03) SpO2 mode; (0A,27); (0C,24); (0D,24); (08,4F).
- States: IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RST_WAIT, WAIT_PERIOD, PUBLISH, ERROR. A phase bit selects init or read.
- IDLE: when enable=1, set init index 0 and go to ISSUE.
- ISSUE: waits until i2c_ready=1, then drives i2c_start=1 for exactly that cycle and goes to WAIT_ACCEPT.
  - rw/reg_addr/data_wr are set on entry to ISSUE and held stable until WAIT_DONE exits.
- WAIT_ACCEPT: on i2c_ready=0, go to WAIT_DONE.
- WAIT_DONE: on i2c_ready=1, the transaction is complete.
  - Read phase: capture i2c_data_rd into byte[idx].
  - Next step:
    - after init entry 0, go to RST_WAIT;
    - after other init entries, advance; after the last entry, set init_done=1 and go to WAIT_PERIOD with the period counter preloaded to SAMPLE_PERIOD (first burst immediate);
    - read phase with idx<5: idx+1, then ISSUE;
    - read phase with idx=5: go to PUBLISH.
- Timeout: counter reset on entry to WAIT_ACCEPT and on entry to WAIT_DONE. If it reaches TIMEOUT, go to ERROR: error=1, init_done=0, i2c_start=0.
- RST_WAIT: count RESET_DELAY cycles, then ISSUE init entry 1.
- Read burst: 6 reads of reg 0x07 (FIFO_DATA), rw=1, idx 0..5.
- Period counter: free-running saturating count, cleared when a burst starts.
  - WAIT_PERIOD leaves once count ≥ SAMPLE_PERIOD-1.
  - If a burst overruns the period, the next burst starts the cycle after PUBLISH; no burst is skipped or queued twice.
- PUBLISH, one cycle:
  - red_data = {byte0[1:0], byte1, byte2};
  - ir_data = {byte3[1:0], byte4, byte5};
  - sample_valid=1; return to WAIT_PERIOD.
- enable falling:
  - In ISSUE before start, in WAIT_PERIOD or in RST_WAIT: go to IDLE next cycle.
  - In WAIT_ACCEPT/WAIT_DONE: finish the current transaction (no new start), then IDLE; no partial PUBLISH.
  - init_done clears on entering IDLE. Re-enable reruns the full init table.
- ERROR: held while enable=1; enable=0 returns to IDLE and clears error.
- i2c_start is never asserted while i2c_ready=0 and never for two consecutive cycles.

Decomposition:
- Shared package max30102_pkg holds:
  - register address constants (MODE_CONFIG 0x09, SPO2_CONFIG 0x0A, LED1_PA 0x0C, LED2_PA 0x0D, FIFO_CONFIG 0x08, FIFO_DATA 0x07);
  - init data constants and INIT_LEN=6;
  - state encoding localparams.
- One sub-module: max30102_init_rom, combinational index -> {reg,data}.

Test Plan:
- Behavioral master (ready drops 1 cycle after start, rises 20 cycles later), enable=1 -> 6 writes in table order: (09,40), 1000-cycle gap, (09,03),(0A,27),(0C,24),(0D,24),(08,4F); init_done=1 after the last.
- Master read data 0xFD,0x23,0x45,0x01,0x67,0x89 -> sample_valid pulse; red_data=18'h12345, ir_data=18'h16789.
- SAMPLE_PERIOD=200 -> burst starts exactly 200 cycles apart. With master latency 50 cycles/transaction (overrun) -> next burst begins 1 cycle after PUBLISH.
- Master never drops ready after start -> error=1 after TIMEOUT cycles, init_done=0, no further i2c_start; enable=0 -> error=0, IDLE.
- enable=0 during read idx 3 WAIT_DONE -> transaction completes, no start issued, no sample_valid, busy=0; re-enable -> init table replays from (09,40).
- rst_n pulsed low mid-burst -> i2c_start=0, all outputs 0 immediately (async); the sequence restarts cleanly after release.
